// File: rtl/router_fifo_pkg.sv
// Shared router definitions: FIFO geometry defaults and header byte field slices.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package router_fifo_pkg;

   // Default per-destination FIFO geometry.
   localparam int unsigned FIFO_DEPTH  = 16;
   localparam int unsigned FIFO_WIDTH  = 8;

   // Header byte layout: [7:2] payload length, [1:0] destination address.
   localparam int unsigned HDR_LEN_MSB = 7;
   localparam int unsigned HDR_LEN_LSB = 2;
   localparam int unsigned DEST_MSB    = 1;
   localparam int unsigned DEST_LSB    = 0;

   // Words still to be presented after a header: payload length plus the parity byte.
   function automatic logic [6:0] pkt_read_count(input logic [5:0] hdr_len);
      return {1'b0, hdr_len} + 7'd1;
   endfunction

endpackage

// File: rtl/router_fifo.sv
// Per-destination packet FIFO: stores header/payload/parity bytes and tags the header word.
// Latency: write visible on empty the same edge; read data registered, valid one cycle after read_enb.
// Backpressure: writes while full are dropped; reads while empty are ignored; output idles at 0 between packets.
module router_fifo
   import router_fifo_pkg::*;
#(
   parameter int unsigned DEPTH = FIFO_DEPTH,
   parameter int unsigned WIDTH = FIFO_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             soft_reset,
   input  logic             write_enb,
   input  logic             read_enb,
   input  logic             lfd_state,
   input  logic [WIDTH-1:0] data_in,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] data_out
);

   localparam int unsigned AW = $clog2(DEPTH);

   // Pointers carry one extra MSB so equal low bits can be told apart as full or empty.
   logic [AW:0]    wr_ptr;
   logic [AW:0]    rd_ptr;
   logic [WIDTH:0] mem [DEPTH];
   logic           lfd_d;
   logic [6:0]     rd_count;

   logic           clr;
   logic           do_wr;
   logic           do_rd;
   logic [WIDTH:0] rd_word;
   logic           rd_hdr;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   // Qualify requests against the flags as they stand at the start of the cycle.
   always_comb begin
      clr     = reset | soft_reset;
      do_wr   = write_enb & ~full;
      do_rd   = read_enb & ~empty;
      rd_word = mem[rd_ptr[AW-1:0]];
      rd_hdr  = rd_word[WIDTH];
   end

   // Header flag delayed to line up with the header byte from the register stage.
   always_ff @(posedge clock) begin
      if (clr) begin
         lfd_d <= 1'b0;
      end else begin
         lfd_d <= lfd_state;
      end
   end

   // Storage array: cleared on either reset, otherwise written at the write pointer.
   always_ff @(posedge clock) begin
      if (clr) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (do_wr) begin
         mem[wr_ptr[AW-1:0]] <= {lfd_d, data_in};
      end
   end

   // Pointer advance; both wrap naturally through the extra MSB.
   always_ff @(posedge clock) begin
      if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_wr) begin
            wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
         end
         if (do_rd) begin
            rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
         end
      end
   end

   // Output byte and packet countdown: a header reloads the count, and the output
   // drops to 0 once the count is exhausted so stray bytes outside a packet are discarded.
   always_ff @(posedge clock) begin
      if (clr) begin
         data_out <= '0;
         rd_count <= '0;
      end else if (do_rd && rd_hdr) begin
         data_out <= rd_word[WIDTH-1:0];
         rd_count <= pkt_read_count(rd_word[HDR_LEN_MSB:HDR_LEN_LSB]);
      end else if (do_rd && (rd_count != 7'd0)) begin
         data_out <= rd_word[WIDTH-1:0];
         rd_count <= rd_count - 7'd1;
      end else if (rd_count == 7'd0) begin
         data_out <= '0;
      end
   end

endmodule

// File: tb/tb_router_fifo.sv
// Self-checking bench for router_fifo: queue-based scoreboard plus directed packet scenarios.
// Latency: compares outputs 1 time unit after every rising edge.
// Backpressure: scoreboard drops writes at full and ignores reads at empty, as the FIFO must.
module tb_router_fifo;

   localparam int DEPTH = 16;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       soft_reset = 1'b0;
   logic       write_enb = 1'b0;
   logic       read_enb = 1'b0;
   logic       lfd_state = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       full;
   logic       empty;
   logic [7:0] data_out;

   int checks = 0;
   int failures = 0;

   // Scoreboard: stored words queued on accepted writes, popped on accepted reads.
   logic [8:0] mq [$];
   logic       m_lfd_d = 1'b0;
   logic [6:0] m_cnt = 7'd0;
   logic [7:0] m_dout = 8'h00;
   int         nread = 0;

   logic [7:0] pkt_exp [5] = '{8'h0C, 8'hA1, 8'hA2, 8'hA3, 8'hAC};
   logic [7:0] sd [40];
   logic       sh [40];

   router_fifo #(.DEPTH(16), .WIDTH(8)) dut (
      .clock      (clock),
      .reset      (reset),
      .soft_reset (soft_reset),
      .write_enb  (write_enb),
      .read_enb   (read_enb),
      .lfd_state  (lfd_state),
      .data_in    (data_in),
      .full       (full),
      .empty      (empty),
      .data_out   (data_out)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock: drive at the falling edge, advance the scoreboard, compare after the rising edge.
   task automatic step(input logic rs, input logic srs, input logic we, input logic re,
                       input logic lfd, input logic [7:0] din);
      logic [8:0] w;
      logic       m_full;
      logic       m_empty;
      @(negedge clock);
      reset      = rs;
      soft_reset = srs;
      write_enb  = we;
      read_enb   = re;
      lfd_state  = lfd;
      data_in    = din;
      m_full  = (mq.size() == DEPTH);
      m_empty = (mq.size() == 0);
      if (rs || srs) begin
         mq.delete();
         m_cnt   = 7'd0;
         m_dout  = 8'h00;
         m_lfd_d = 1'b0;
      end else begin
         if (re && !m_empty) begin
            w = mq.pop_front();
            nread++;
            if (w[8]) begin
               m_dout = w[7:0];
               m_cnt  = {1'b0, w[7:2]} + 7'd1;
            end else if (m_cnt != 7'd0) begin
               m_dout = w[7:0];
               m_cnt  = m_cnt - 7'd1;
            end else begin
               m_dout = 8'h00;
            end
         end else if (m_cnt == 7'd0) begin
            m_dout = 8'h00;
         end
         if (we && !m_full) mq.push_back({m_lfd_d, din});
         m_lfd_d = lfd;
      end
      @(posedge clock);
      #1;
      check("dout", data_out, m_dout);
      check("full", full, mq.size() == DEPTH);
      check("empty", empty, mq.size() == 0);
   endtask

   initial begin
      int  wi;
      int  cyc;
      logic cur;
      logic nxt;
      logic [7:0] par;

      // Reset state
      step(1, 0, 0, 0, 0, 8'h00);
      step(1, 0, 0, 0, 0, 8'h00);
      check("rst_full", full, 0);
      check("rst_empty", empty, 1);
      check("rst_dout", data_out, 0);

      // Basic packet: lfd one cycle before the header, then payload and parity
      step(0, 0, 0, 0, 1, 8'h00);
      step(0, 0, 1, 0, 0, 8'h0C);
      check("pkt_empty_fall", empty, 0);
      step(0, 0, 1, 0, 0, 8'hA1);
      step(0, 0, 1, 0, 0, 8'hA2);
      step(0, 0, 1, 0, 0, 8'hA3);
      step(0, 0, 1, 0, 0, 8'hAC);
      for (int k = 0; k < 5; k++) begin
         step(0, 0, 0, 1, 0, 8'h00);
         check("pkt_byte", data_out, pkt_exp[k]);
      end
      check("pkt_cnt_zero", dut.rd_count, 0);
      step(0, 0, 0, 0, 0, 8'h00);
      check("pkt_idle", data_out, 0);
      check("pkt_empty", empty, 1);

      // Fill to full, drop a 17th write, then read and write together at full
      step(1, 0, 0, 0, 0, 8'h00);
      step(0, 0, 0, 0, 1, 8'h00);
      step(0, 0, 1, 0, 0, 8'hFC);
      for (int k = 1; k < 16; k++) step(0, 0, 1, 0, 0, 8'h10 + 8'(k));
      check("full_set", full, 1);
      step(0, 0, 1, 0, 0, 8'hFF);
      check("full_drop", full, 1);
      step(0, 0, 1, 1, 0, 8'hFF);
      check("full_rw_hdr", data_out, 8'hFC);
      check("full_rw_fall", full, 0);
      step(0, 0, 1, 0, 0, 8'h2F);
      check("full_refill", full, 1);
      for (int k = 0; k < 16; k++) begin
         step(0, 0, 0, 1, 0, 8'h00);
         check("full_no_ff", data_out == 8'hFF, 0);
      end
      check("full_last", data_out, 8'h2F);
      check("full_drained", empty, 1);

      // Simultaneous read and write at empty, mid-packet
      step(1, 0, 0, 0, 0, 8'h00);
      step(0, 0, 0, 0, 1, 8'h00);
      step(0, 0, 1, 0, 0, 8'h08);
      step(0, 0, 1, 0, 0, 8'hB1);
      step(0, 0, 0, 1, 0, 8'h00);
      step(0, 0, 0, 1, 0, 8'h00);
      check("rwe_pre", data_out, 8'hB1);
      step(0, 0, 1, 1, 0, 8'h77);
      check("rwe_dout_hold", data_out, 8'hB1);
      check("rwe_stored", empty, 0);
      step(0, 0, 0, 1, 0, 8'h00);
      check("rwe_read", data_out, 8'h77);

      // Soft reset part-way through a 6-word packet
      step(1, 0, 0, 0, 0, 8'h00);
      step(0, 0, 0, 0, 1, 8'h00);
      step(0, 0, 1, 0, 0, 8'h11);
      step(0, 0, 1, 0, 0, 8'hC1);
      step(0, 0, 1, 1, 0, 8'hC2);
      step(0, 0, 0, 1, 0, 8'h00);
      check("srst_pre", data_out, 8'hC1);
      step(0, 1, 1, 1, 0, 8'hEE);
      check("srst_empty", empty, 1);
      check("srst_dout", data_out, 0);
      check("srst_cnt", dut.rd_count, 0);
      step(0, 0, 0, 0, 0, 8'h00);
      check("srst_idle", data_out, 0);

      // Wrap-around: 8 packets of 5 words with random write gaps and interleaved reads
      for (int p = 0; p < 8; p++) begin
         sd[p*5] = 8'((3 << 2) | (p % 3));
         sh[p*5] = 1'b1;
         par = sd[p*5];
         for (int b = 1; b < 4; b++) begin
            sd[p*5+b] = 8'($urandom_range(0, 255));
            sh[p*5+b] = 1'b0;
            par = par ^ sd[p*5+b];
         end
         sd[p*5+4] = par;
         sh[p*5+4] = 1'b0;
      end
      step(1, 0, 0, 0, 0, 8'h00);
      nread = 0;
      wi = 0;
      cyc = 0;
      nxt = 1'b0;
      while ((wi < 40 || mq.size() != 0) && cyc < 2000) begin
         cur = nxt;
         nxt = (wi + int'(cur) < 40) && ($urandom_range(0, 1) == 1) && (mq.size() < DEPTH - 3);
         step(0, 0, cur, $urandom_range(0, 3) != 0, nxt && sh[wi + int'(cur)],
              cur ? sd[wi] : 8'h00);
         if (cur) wi++;
         cyc++;
      end
      check("wrap_written", wi, 40);
      check("wrap_read", nread, 40);
      check("wrap_wptr", dut.wr_ptr, 8);
      check("wrap_rptr", dut.rd_ptr, 8);

      // Read on empty: output stays idle and pointers hold
      step(1, 0, 0, 0, 0, 8'h00);
      for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 0, 8'h00);
      check("rde_dout", data_out, 0);
      check("rde_rptr", dut.rd_ptr, 0);
      check("rde_wptr", dut.wr_ptr, 0);
      check("rde_empty", empty, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/router_fifo.md
# router_fifo

Per-destination output FIFO for the 1x3 router. Three instances sit directly downstream of the router register stage, one per destination port. Each instance stores the byte stream (header, payload, parity) that the register stage drives, tagging the header word. It presents packets to the destination reader with a per-packet read countdown, so the output returns to idle between packets.

## Interface
- `DEPTH`, default 16: number of storage words; must be a power of two.
- `WIDTH`, default 8: data byte width. Each stored word is WIDTH+1 bits: bit WIDTH is the header flag.
- `clock`, in, 1: single clock; all logic is on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `soft_reset`, in, 1: synchronous, active-high. Asserted when the destination reader times out. Same clearing effect as `reset`.
- `write_enb`, in, 1: write request from the router FSM.
- `read_enb`, in, 1: read request from the destination port.
- `lfd_state`, in, 1: FSM "load first data" state; marks the header.
- `data_in`, in, WIDTH: byte from the register stage.
- `full`, out, 1: combinational; asserted when DEPTH words are stored.
- `empty`, out, 1: combinational; asserted when 0 words are stored.
- `data_out`, out, WIDTH: registered read data; 0 when idle.

## Operation
- **Pointers.**
  - Write and read pointers are log2(DEPTH)+1 bits wide; the extra MSB distinguishes full from empty.
  - `empty`: the two pointers are equal.
  - `full`: MSBs differ and the lower bits are equal.
- **Header flag.**
  - `lfd_d` is `lfd_state` registered by one cycle, so it aligns with the header byte that the register stage drives one cycle after `lfd_state`.
  - Stored word = {`lfd_d`, `data_in`}.
- **Write.**
  - Occurs when `write_enb` && !`full`, sampled at the edge.
  - Stores the word at the write pointer, then increments the write pointer (it wraps naturally).
  - A write while `full` is dropped: no pointer or memory change.
- **Read.**
  - Occurs when `read_enb` && !`empty`.
  - `data_out` <= mem[rd_ptr][WIDTH-1:0], then the read pointer increments.
- **Packet countdown.** A 7-bit register `rd_count`.
  - When the word being read has its header flag set, `rd_count` <= data[7:2] + 1 (payload length plus parity byte).
  - On every other successful read with `rd_count` != 0, `rd_count` decrements.
- **Idle output.**
  - When `rd_count` == 0 and no header is being read, `data_out` <= 0, whether or not `read_enb` is asserted.
  - A read of a non-header word while `rd_count` == 0 still advances the pointer, but `data_out` is 0. This is a protocol-error case: the byte is discarded.
- **Simultaneous read and write.**
  - Both occur when their individual conditions hold.
  - When `full`, the read proceeds and the write is dropped (the `full` flag sampled at the start of the cycle governs).
  - When `empty`, the write proceeds and the read is ignored.
- **Reset.**
  - `reset` or `soft_reset` clears the pointers, `rd_count`, `lfd_d`, and `data_out` to 0, and every memory word to 0.
  - Reset wins over any simultaneous read or write.
  - A reset mid-packet discards the remainder of that packet.
- **Reset values:** `full`=0, `empty`=1, `data_out`=0.

## Timing
- Write-to-`empty` deassert: 1 cycle. `empty` falls on the edge that performs the first write.
- Read latency: 1 cycle. `data_out` is valid the cycle after the read-enable edge.
- `full` and `empty` are decoded from the registered pointers, so they change only on edges.
- Header read to first payload on `data_out`: the next read cycle. The countdown reaches 0 on the parity byte's read edge.
- Back-to-back packets need no idle cycle: a header read while `rd_count` == 0 reloads the counter.

## Structure
- Shared router package holds:
  - the `WIDTH` and `DEPTH` defaults;
  - the header length field slice (bits 7:2);
  - the destination address slice (bits 1:0).
- A single module; no sub-module. Memory is an inferred array.

## Test plan
- **Basic packet:** reset, then write header 0x0C with `lfd_state` one cycle earlier, then bytes 0xA1, 0xA2, 0xA3, then parity. Read 5 words. Required: `data_out` = 0x0C, 0xA1, 0xA2, 0xA3, parity, then 0 afterward; `empty`=1.
- **Full:** write 16 words. Required: `full`=1. A 17th write with 0xFF is dropped, and a full read-back shows no 0xFF.
- **Simultaneous read and write at full:** 1 word leaves, the incoming word is dropped, `full` falls to 0 for one cycle. Simultaneous read and write at empty: the word is stored and `data_out` is unchanged.
- **Soft reset:** after 3 words of a 6-word packet, pulse `soft_reset`. Required: `empty`=1, `data_out`=0 next cycle, `rd_count`=0.
- **Wrap-around:** 40 words across several packets with interleaved reads. Required: pointers wrap and data order is preserved.
- **Read on empty:** `read_enb`=1 with FIFO empty. Required: `data_out` stays 0 and the pointers are unchanged.
